// File: rtl/mode_pkg.sv
// rtl/mode_pkg.sv - shared mode, edit-field and scheduler encodings for the mode controller
package mode_pkg;

    typedef enum logic [3:0] {
        MODE_CLOCK = 4'b0000,
        MODE_SW    = 4'b0001,
        MODE_TIMER = 4'b0010,
        MODE_ULTRA = 4'b0100,
        MODE_DHT   = 4'b1000
    } mode_t;

    typedef enum logic [1:0] {
        EDIT_OFF = 2'b00,
        EDIT_F0  = 2'b01,
        EDIT_F1  = 2'b10,
        EDIT_F2  = 2'b11
    } edit_t;

    typedef enum logic [1:0] {
        SCH_IDLE  = 2'b00,
        SCH_START = 2'b01,
        SCH_BUSY  = 2'b10,
        SCH_WAIT  = 2'b11
    } sched_t;

    localparam int IDLE_TIMEOUT_DEF = 30;
    localparam int MEAS_PERIOD_DEF  = 2;
    localparam int MEAS_WDOG_DEF    = 3;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_CLOCK: return MODE_SW;
            MODE_SW:    return MODE_TIMER;
            MODE_TIMER: return MODE_ULTRA;
            MODE_ULTRA: return MODE_DHT;
            default:    return MODE_CLOCK;
        endcase
    endfunction

    function automatic logic is_meas(input logic [3:0] m);
        return (m == MODE_ULTRA) || (m == MODE_DHT);
    endfunction

endpackage

// File: rtl/meas_scheduler.sv
// rtl/meas_scheduler.sv - start/busy/wait scheduler for the ultrasonic and DHT sensors
module meas_scheduler
    import mode_pkg::*;
#(
    parameter int MEAS_PERIOD = MEAS_PERIOD_DEF,
    parameter int MEAS_WDOG   = MEAS_WDOG_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] mode,
    input  logic       tick,
    input  logic       ultra_done,
    input  logic       dht_done,
    output logic       ultra_start,
    output logic       dht_start,
    output logic       sensor_err
);

    localparam int CMAX = (MEAS_PERIOD > MEAS_WDOG) ? MEAS_PERIOD : MEAS_WDOG;
    localparam int CW   = $clog2(CMAX + 1);

    sched_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sel_q, sel_d;    // sensor of the outstanding request: 1 = DHT
    logic          err_q, err_d;
    logic          valid_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SCH_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sel_d      = sel_q;
        err_d      = err_q;
        valid_done = sel_q ? dht_done : ultra_done;
        case (state_q)
            SCH_IDLE: begin
                if (is_meas(mode)) begin
                    state_d = SCH_START;
                    sel_d   = (mode == MODE_DHT);
                end
            end
            SCH_START: begin
                state_d = SCH_BUSY;
                cnt_d   = '0;
            end
            SCH_BUSY: begin
                if (valid_done) begin
                    err_d   = 1'b0;
                    state_d = SCH_WAIT;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CW'(MEAS_WDOG - 1)) begin
                        err_d   = 1'b1;
                        state_d = SCH_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // Sensor is re-selected here so a mode change made during BUSY takes effect next round.
                if (!is_meas(mode)) begin
                    state_d = SCH_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (cnt_q == CW'(MEAS_PERIOD - 1)) begin
                        state_d = SCH_START;
                        sel_d   = (mode == MODE_DHT);
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
        endcase
    end

    assign ultra_start = (state_q == SCH_START) && !sel_q;
    assign dht_start   = (state_q == SCH_START) &&  sel_q;
    assign sensor_err  = err_q;

endmodule

// File: rtl/mode_controller.sv
// rtl/mode_controller.sv - display mode FSM, edit-field FSM and idle timeout with sensor scheduler
module mode_controller
    import mode_pkg::*;
#(
    parameter int IDLE_TIMEOUT = IDLE_TIMEOUT_DEF,
    parameter int MEAS_PERIOD  = MEAS_PERIOD_DEF,
    parameter int MEAS_WDOG    = MEAS_WDOG_DEF
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iBtn_Mode,
    input  logic       iBtn_Set,
    input  logic       iBtn_Next,
    input  logic       iTick_1Hz,
    input  logic       iUltra_Done,
    input  logic       iDHT_Done,
    output logic [3:0] oMode,
    output logic [1:0] oSet,
    output logic       oUltra_Start,
    output logic       oDHT_Start,
    output logic       oSensor_Err
);

    localparam int IW = $clog2(IDLE_TIMEOUT + 1);

    mode_t         mode_q, mode_d;
    edit_t         edit_q, edit_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          any_btn;
    logic          armed;

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            mode_q <= MODE_CLOCK;
            edit_q <= EDIT_OFF;
            idle_q <= '0;
        end else begin
            mode_q <= mode_d;
            edit_q <= edit_d;
            idle_q <= idle_d;
        end
    end

    always_comb begin
        mode_d  = mode_q;
        edit_d  = edit_q;
        idle_d  = idle_q;
        any_btn = iBtn_Mode || iBtn_Set || iBtn_Next;
        armed   = (edit_q != EDIT_OFF) || is_meas(mode_q);

        if (edit_q == EDIT_OFF) begin
            if (iBtn_Mode) begin
                mode_d = next_mode(mode_q);
            end else if (iBtn_Set && (mode_q == MODE_CLOCK || mode_q == MODE_TIMER)) begin
                edit_d = EDIT_F0;
            end
        end else begin
            if (iBtn_Set) begin
                edit_d = EDIT_OFF;
            end else if (iBtn_Next) begin
                edit_d = (edit_q == EDIT_F2) ? EDIT_F0 : edit_t'(edit_q + 2'd1);
            end
        end

        // A button pulse in the same cycle as the final tick wins: the user is active.
        if (any_btn) begin
            idle_d = '0;
        end else if (iTick_1Hz) begin
            if (idle_q >= IW'(IDLE_TIMEOUT - 1)) begin
                if (armed) begin
                    idle_d = '0;
                    edit_d = EDIT_OFF;
                    if (is_meas(mode_q)) begin
                        mode_d = MODE_CLOCK;
                    end
                end else begin
                    idle_d = IW'(IDLE_TIMEOUT);
                end
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    assign oMode = mode_q;
    assign oSet  = edit_q;

    meas_scheduler #(
        .MEAS_PERIOD(MEAS_PERIOD),
        .MEAS_WDOG  (MEAS_WDOG)
    ) u_sched (
        .clk        (iClk),
        .rst_n      (iRst_n),
        .mode       (mode_q),
        .tick       (iTick_1Hz),
        .ultra_done (iUltra_Done),
        .dht_done   (iDHT_Done),
        .ultra_start(oUltra_Start),
        .dht_start  (oDHT_Start),
        .sensor_err (oSensor_Err)
    );

endmodule

// File: tb/tb_mode_controller.sv
// tb/tb_mode_controller.sv - directed self-checking bench for mode_controller
module tb_mode_controller;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic       iBtn_Mode, iBtn_Set, iBtn_Next, iTick_1Hz, iUltra_Done, iDHT_Done;
    logic [3:0] oMode;
    logic [1:0] oSet;
    logic       oUltra_Start, oDHT_Start, oSensor_Err;

    int checks = 0;
    int errors = 0;
    int ultra_pulses = 0;
    int dht_pulses = 0;
    int both_high = 0;
    int u0, d0;
    logic [3:0] seq [5];

    always #5 iClk = ~iClk;

    mode_controller dut (
        .iClk        (iClk),
        .iRst_n      (iRst_n),
        .iBtn_Mode   (iBtn_Mode),
        .iBtn_Set    (iBtn_Set),
        .iBtn_Next   (iBtn_Next),
        .iTick_1Hz   (iTick_1Hz),
        .iUltra_Done (iUltra_Done),
        .iDHT_Done   (iDHT_Done),
        .oMode       (oMode),
        .oSet        (oSet),
        .oUltra_Start(oUltra_Start),
        .oDHT_Start  (oDHT_Start),
        .oSensor_Err (oSensor_Err)
    );

    always @(negedge iClk) begin
        if (oUltra_Start) ultra_pulses++;
        if (oDHT_Start) dht_pulses++;
        if (oUltra_Start && oDHT_Start) both_high++;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic cycs(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic tick();
        iTick_1Hz = 1'b1; cyc(); iTick_1Hz = 1'b0;
    endtask

    task automatic press_mode();
        iBtn_Mode = 1'b1; cyc(); iBtn_Mode = 1'b0;
    endtask

    task automatic press_set();
        iBtn_Set = 1'b1; cyc(); iBtn_Set = 1'b0;
    endtask

    task automatic press_next();
        iBtn_Next = 1'b1; cyc(); iBtn_Next = 1'b0;
    endtask

    task automatic do_reset();
        iRst_n = 1'b0; cycs(2); iRst_n = 1'b1; cyc();
    endtask

    initial begin
        iRst_n = 1'b0;
        iBtn_Mode = 1'b0; iBtn_Set = 1'b0; iBtn_Next = 1'b0;
        iTick_1Hz = 1'b0; iUltra_Done = 1'b0; iDHT_Done = 1'b0;
        cycs(2);
        chk("rst_mode", {4'h0, oMode}, 8'h00);
        chk("rst_set", {6'h0, oSet}, 8'h00);
        chk("rst_ustart", {7'h0, oUltra_Start}, 8'h00);
        chk("rst_dstart", {7'h0, oDHT_Start}, 8'h00);
        chk("rst_err", {7'h0, oSensor_Err}, 8'h00);
        iRst_n = 1'b1; cyc();

        // Mode ring, one cycle latency, holds without a pulse
        seq = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
        for (int i = 0; i < 5; i++) begin
            press_mode();
            chk("mode_step", {4'h0, oMode}, {4'h0, seq[i]});
            cyc();
            chk("mode_hold", {4'h0, oMode}, {4'h0, seq[i]});
        end

        // Edit FSM in CLOCK
        do_reset();
        press_next();  chk("next_in_off", {6'h0, oSet}, 8'h00);
        press_set();   chk("set_f0", {6'h0, oSet}, 8'h01);
        press_next();  chk("next_f1", {6'h0, oSet}, 8'h02);
        press_next();  chk("next_f2", {6'h0, oSet}, 8'h03);
        press_next();  chk("next_wrap", {6'h0, oSet}, 8'h01);
        press_mode();  chk("mode_in_edit", {4'h0, oMode}, 8'h00);
        chk("set_kept", {6'h0, oSet}, 8'h01);
        press_set();   chk("set_exit", {6'h0, oSet}, 8'h00);
        press_mode();  chk("to_sw", {4'h0, oMode}, 8'h01);
        press_set();   chk("set_in_sw", {6'h0, oSet}, 8'h00);
        iBtn_Mode = 1'b1; iBtn_Set = 1'b1; cyc(); iBtn_Mode = 1'b0; iBtn_Set = 1'b0;
        chk("prio_mode", {4'h0, oMode}, 8'h02);
        chk("prio_set_drop", {6'h0, oSet}, 8'h00);
        press_set();   chk("set_timer", {6'h0, oSet}, 8'h01);
        iBtn_Set = 1'b1; iBtn_Next = 1'b1; cyc(); iBtn_Set = 1'b0; iBtn_Next = 1'b0;
        chk("set_next_exit", {6'h0, oSet}, 8'h00);

        // Idle timeout of an edit in TIMER
        press_set(); press_next();
        chk("timer_f1", {6'h0, oSet}, 8'h02);
        for (int i = 0; i < 29; i++) tick();
        chk("edit_before_to", {6'h0, oSet}, 8'h02);
        tick();
        chk("edit_timeout", {6'h0, oSet}, 8'h00);
        chk("timer_kept", {4'h0, oMode}, 8'h02);

        // ULTRA measurement cycle
        do_reset();
        press_mode(); press_mode(); press_mode();
        chk("ultra_entry", {4'h0, oMode}, 8'h04);
        chk("no_start_at_entry", {7'h0, oUltra_Start}, 8'h00);
        d0 = dht_pulses;
        cyc();
        chk("ustart", {7'h0, oUltra_Start}, 8'h01);
        chk("no_dstart", {7'h0, oDHT_Start}, 8'h00);
        cyc();
        chk("ustart_single", {7'h0, oUltra_Start}, 8'h00);
        iDHT_Done = 1'b1; cyc(); iDHT_Done = 1'b0;
        tick(); chk("other_done_ign1", {7'h0, oUltra_Start}, 8'h00);
        tick(); chk("other_done_ign2", {7'h0, oUltra_Start}, 8'h00);
        iUltra_Done = 1'b1; cyc(); iUltra_Done = 1'b0;
        chk("done_no_err", {7'h0, oSensor_Err}, 8'h00);
        tick(); chk("wait_tick1", {7'h0, oUltra_Start}, 8'h00);
        tick(); chk("restart", {7'h0, oUltra_Start}, 8'h01);
        chk("no_dht_in_ultra", 8'(dht_pulses), 8'(d0));

        // Mode change while BUSY does not abort the ULTRA request
        cyc();
        press_mode();
        chk("to_dht", {4'h0, oMode}, 8'h08);
        cycs(3);
        chk("no_dstart_busy", {7'h0, oDHT_Start}, 8'h00);
        iUltra_Done = 1'b1; cyc(); iUltra_Done = 1'b0;
        tick(); chk("dwait1", {7'h0, oDHT_Start}, 8'h00);
        tick(); chk("dstart", {7'h0, oDHT_Start}, 8'h01);
        chk("dstart_excl", {7'h0, oUltra_Start}, 8'h00);

        // DHT watchdog
        cyc();
        tick(); tick();
        chk("wdog_pre", {7'h0, oSensor_Err}, 8'h00);
        tick();
        chk("wdog_err", {7'h0, oSensor_Err}, 8'h01);
        tick(); tick();
        chk("dstart_again", {7'h0, oDHT_Start}, 8'h01);
        chk("err_sticky", {7'h0, oSensor_Err}, 8'h01);
        cyc();
        iDHT_Done = 1'b1; cyc(); iDHT_Done = 1'b0;
        chk("err_clear", {7'h0, oSensor_Err}, 8'h00);

        // ULTRA idle timeout, then saturation in CLOCK
        press_mode(); press_mode(); press_mode(); press_mode();
        chk("back_ultra", {4'h0, oMode}, 8'h04);
        for (int i = 0; i < 29; i++) tick();
        chk("ultra_before_to", {4'h0, oMode}, 8'h04);
        tick();
        chk("ultra_timeout", {4'h0, oMode}, 8'h00);
        for (int i = 0; i < 40; i++) tick();
        chk("sat_mode", {4'h0, oMode}, 8'h00);
        chk("sat_set", {6'h0, oSet}, 8'h00);
        press_set();
        chk("set_after_sat", {6'h0, oSet}, 8'h01);
        press_set();

        // Reset while BUSY discards the request
        do_reset();
        press_mode(); press_mode(); press_mode();
        cyc(); cyc();
        iRst_n = 1'b0;
        #1;
        chk("arst_mode", {4'h0, oMode}, 8'h00);
        chk("arst_set", {6'h0, oSet}, 8'h00);
        chk("arst_ustart", {7'h0, oUltra_Start}, 8'h00);
        chk("arst_err", {7'h0, oSensor_Err}, 8'h00);
        cycs(2);
        iRst_n = 1'b1;
        cyc();
        u0 = ultra_pulses;
        d0 = dht_pulses;
        iUltra_Done = 1'b1; cyc(); iUltra_Done = 1'b0;
        cycs(10);
        chk("post_rst_ustarts", 8'(ultra_pulses), 8'(u0));
        chk("post_rst_dstarts", 8'(dht_pulses), 8'(d0));
        chk("post_rst_mode", {4'h0, oMode}, 8'h00);
        chk("post_rst_err", {7'h0, oSensor_Err}, 8'h00);
        chk("never_both", 8'(both_high), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mode_controller.md
MODE_CONTROLLER -- requirements
Module: Mode_Controller

Interface
REQ-001 SHALL have parameter IDLE_TIMEOUT, default 30, meaning the number of 1 Hz ticks without a button pulse before the idle timeout fires.
REQ-002 SHALL have parameter MEAS_PERIOD, default 2, meaning the number of 1 Hz ticks between sensor measurement starts.
REQ-003 SHALL have parameter MEAS_WDOG, default 3, meaning the number of 1 Hz ticks to wait for sensor done before declaring an error.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, as decided: iClk and iRst_n.
REQ-005 Ports, in order:
- iClk  in  1  system clock.
- iRst_n  in  1  asynchronous active-low reset.
- iBtn_Mode  in  1  debounced single-cycle pulse; next mode.
- iBtn_Set  in  1  debounced single-cycle pulse; enter or exit edit.
- iBtn_Next  in  1  debounced single-cycle pulse; next edit field.
- iTick_1Hz  in  1  single-cycle pulse, once per second.
- iUltra_Done  in  1  pulse; ultrasonic measurement complete.
- iDHT_Done  in  1  pulse; DHT measurement complete.
- oMode  out  4  mode code driven to the display mux.
- oSet  out  2  edit-field code driven to the clock and timer set logic.
- oUltra_Start  out  1  single-cycle start pulse to the ultrasonic sensor.
- oDHT_Start  out  1  single-cycle start pulse to the DHT sensor.
- oSensor_Err  out  1  sticky watchdog error flag.

Function
REQ-006 Mode codes SHALL be: CLOCK 4'b0000, SW 4'b0001, TIMER 4'b0010, ULTRA 4'b0100, DHT 4'b1000; no other code is ever driven.
REQ-007 A mode FSM SHALL step CLOCK -> SW -> TIMER -> ULTRA -> DHT -> CLOCK on each iBtn_Mode pulse while not editing.
- oMode is registered and changes on the clock edge after the pulse (latency 1).
REQ-008 An edit FSM SHALL use states OFF (oSet=00) and F0/F1/F2 (oSet=01/10/11).
- iBtn_Set in OFF enters F0, only when the mode is CLOCK or TIMER.
- iBtn_Set in any F state returns to OFF.
- iBtn_Next steps F0 -> F1 -> F2 -> F0.
- iBtn_Next in OFF is ignored.
REQ-009 While editing, iBtn_Mode SHALL be ignored.
REQ-010 iBtn_Set in SW, ULTRA or DHT SHALL be ignored.
REQ-011 Simultaneous pulses while in OFF SHALL resolve by priority Mode > Set > Next; lower-priority pulses in the same cycle are dropped.
REQ-012 Simultaneous Set and Next while editing SHALL resolve as Set (exit edit).
REQ-013 An idle counter SHALL clear on any button pulse and increment on each iTick_1Hz.
- On reaching IDLE_TIMEOUT, an active edit returns to OFF.
- On reaching IDLE_TIMEOUT, a mode of ULTRA or DHT returns to CLOCK.
- The counter then clears.
- In CLOCK/SW/TIMER with edit OFF, the counter saturates at IDLE_TIMEOUT and no action fires.
REQ-014 A measurement scheduler SHALL use states IDLE, START, BUSY and WAIT.
- Entry into ULTRA or DHT from IDLE issues START on the next cycle.
- START drives exactly one pulse on the start output of the current sensor, then goes to BUSY.
REQ-015 BUSY SHALL end on the Done pulse of the sensor that was started.
- Done from the other sensor is ignored.
- Done received outside BUSY is ignored.
- A valid Done clears oSensor_Err.
REQ-016 From BUSY, the scheduler SHALL go to WAIT, then re-enter START after MEAS_PERIOD ticks if the mode is still ULTRA or DHT; otherwise it goes to IDLE.
REQ-017 If BUSY lasts MEAS_WDOG ticks without a valid Done, the scheduler SHALL set oSensor_Err and go to WAIT.
REQ-018 A mode change during BUSY SHALL NOT abort the measurement in progress.
- A start for the new sensor is issued only after BUSY ends.
- At most one measurement is outstanding at any time.
REQ-019 oUltra_Start and oDHT_Start SHALL never be high in the same cycle.

Reset
REQ-020 Assertion of iRst_n low SHALL asynchronously force: oMode=CLOCK, oSet=00, both start outputs 0, oSensor_Err=0, scheduler IDLE, idle and tick counters 0.
REQ-021 Reset in mid-measurement SHALL discard the outstanding request; a Done pulse arriving after reset is ignored.

Structure
REQ-022 Mode codes, edit-field codes, scheduler state encodings and the parameter defaults SHALL reside in the shared package Mode_Pkg.
REQ-023 The scheduler (REQ-014..REQ-019) SHALL be the sub-module Meas_Scheduler; the mode FSM, edit FSM and idle counter stay in Mode_Controller.

Verification
REQ-024 Five iBtn_Mode pulses from reset -> oMode 0001, 0010, 0100, 1000, 0000, each one cycle after its pulse.
REQ-025 In CLOCK: Set, Next, Next, Next, then Mode, then Set -> oSet 01, 10, 11, 01; oMode remains 0000 through the Mode pulse; oSet 00 after the final Set.
REQ-026 Enter ULTRA with iUltra_Done returned 5 cycles after each start -> one oUltra_Start pulse one cycle after entry, the next pulse 2 ticks after Done, and no oDHT_Start.
REQ-027 In DHT with iDHT_Done withheld -> oSensor_Err rises after 3 ticks; the next Done clears it.
REQ-028 In TIMER edit F1 with 30 ticks and no button pulse -> oSet 00 and oMode stays 0010; in ULTRA with 30 idle ticks -> oMode 0000.
REQ-029 Drop iRst_n while BUSY in ULTRA, then pulse iUltra_Done after release -> all outputs at reset values and no start pulse issued.
